// File: rtl/n1_pkg.sv
// Shared definitions for the n1_core CPU: opcodes, FSM states and
// instruction field positions.
package n1_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RD_LSB    = 9;
    localparam int RS_LSB    = 6;
    localparam int IMM_W     = 8;
    localparam int REG_IDX_W = 3;

    // Opcodes 1010..1111 are not part of the instruction set.
    function automatic logic is_undefined_op(input logic [3:0] op);
        return op > OP_JZ;
    endfunction

endpackage

// File: rtl/n1_regfile.sv
// General-purpose register file: NUM_REGS x DATA_W, two combinational read
// ports and one write port. Indices at or above NUM_REGS read 0, writes drop.
module n1_regfile
    import n1_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (srst) begin
                    regs_q[gi] <= '0;
                end else if (we && (waddr == REG_IDX_W'(gi))) begin
                    regs_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Priority-free select: an index that matches no register leaves 0.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_a == REG_IDX_W'(i)) rdata_a = regs_q[i];
            if (raddr_b == REG_IDX_W'(i)) rdata_b = regs_q[i];
        end
    end

endmodule

// File: rtl/n1_core.sv
// n1_core: multi-cycle FETCH/EXEC/MEM CPU with internal RAM and loader port.
// Optional macro N1_ILLEGAL_TRAP_EN: undefined opcodes halt and raise err.
module n1_core
    import n1_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RAM_WORDS = 256,
    parameter int NUM_REGS  = 4,
    localparam int ADDR_W   = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic              halted
`ifdef N1_ILLEGAL_TRAP_EN
    ,
    output logic              err
`endif
);

    state_e                 state_q;
    logic [ADDR_W-1:0]      pc_q;
    logic [DATA_W-1:0]      ram_rdata_q;
    logic                   ld_valid_q;
    logic [REG_IDX_W-1:0]   mem_rd_q;
    logic                   mem_is_ld_q;
    logic [7:0]             out_data_q;
    logic                   out_valid_q;
`ifdef N1_ILLEGAL_TRAP_EN
    logic                   err_q;
`endif

    logic [DATA_W-1:0]      mem [RAM_WORDS];

    // The instruction is whatever the RAM returned for the FETCH address.
    logic [DATA_W-1:0]      inst;
    logic [3:0]             op;
    logic [REG_IDX_W-1:0]   rd_idx;
    logic [REG_IDX_W-1:0]   rs_idx;
    logic [ADDR_W-1:0]      iaddr;
    logic [DATA_W-1:0]      imm_ext;
    logic [DATA_W-1:0]      rd_val;
    logic [DATA_W-1:0]      rs_val;

    assign inst    = ram_rdata_q;
    assign op      = inst[OP_MSB:OP_LSB];
    assign rd_idx  = inst[RD_LSB +: REG_IDX_W];
    assign rs_idx  = inst[RS_LSB +: REG_IDX_W];
    assign iaddr   = inst[ADDR_W-1:0];
    assign imm_ext = DATA_W'(inst[IMM_W-1:0]);

    logic [ADDR_W-1:0]      ram_addr_d;
    logic                   ram_we_d;
    logic [DATA_W-1:0]      ram_wdata_d;
    logic                   rf_we_d;
    logic [REG_IDX_W-1:0]   rf_waddr_d;
    logic [DATA_W-1:0]      rf_wdata_d;

    n1_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .srst    (rst),
        .we      (rf_we_d),
        .waddr   (rf_waddr_d),
        .wdata   (rf_wdata_d),
        .raddr_a (rd_idx),
        .rdata_a (rd_val),
        .raddr_b (rs_idx),
        .rdata_b (rs_val)
    );

    // Single RAM port shared by loader (IDLE/HALT) and core (run states).
    always_comb begin
        ram_addr_d  = ld_addr;
        ram_we_d    = 1'b0;
        ram_wdata_d = ld_wdata;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rd_idx;
        rf_wdata_d  = '0;
        case (state_q)
            S_IDLE, S_HALT: begin
                ram_we_d = ld_we;
            end
            S_FETCH: begin
                ram_addr_d = pc_q;
            end
            S_EXEC: begin
                ram_addr_d  = iaddr;
                ram_wdata_d = rd_val;
                case (op)
                    OP_ST:   ram_we_d = 1'b1;
                    OP_MOVI: begin
                        rf_we_d    = 1'b1;
                        rf_wdata_d = imm_ext;
                    end
                    OP_ADD: begin
                        rf_we_d    = 1'b1;
                        rf_wdata_d = rd_val + rs_val;
                    end
                    OP_SUB: begin
                        rf_we_d    = 1'b1;
                        rf_wdata_d = rd_val - rs_val;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                rf_we_d    = mem_is_ld_q;
                rf_waddr_d = mem_rd_q;
                rf_wdata_d = ram_rdata_q;
            end
            default: ;
        endcase
        // A reset aborts any write that would otherwise land this edge.
        if (rst) ram_we_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (ram_we_d) mem[ram_addr_d] <= ram_wdata_d;
        ram_rdata_q <= mem[ram_addr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ld_valid_q  <= 1'b0;
            mem_rd_q    <= '0;
            mem_is_ld_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef N1_ILLEGAL_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            ld_valid_q  <= (state_q == S_IDLE) || (state_q == S_HALT);
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        pc_q    <= '0;
`ifdef N1_ILLEGAL_TRAP_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    pc_q    <= pc_q + ADDR_W'(1);
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    mem_rd_q    <= rd_idx;
                    mem_is_ld_q <= (op == OP_LD);
                    state_q     <= S_FETCH;
                    case (op)
                        OP_LD, OP_OUT: state_q <= S_MEM;
                        OP_HALT:       state_q <= S_HALT;
                        OP_JMP:        pc_q    <= iaddr;
                        OP_JZ: begin
                            if (rd_val == '0) pc_q <= iaddr;
                        end
                        default: begin
`ifdef N1_ILLEGAL_TRAP_EN
                            if (is_undefined_op(op)) begin
                                state_q <= S_HALT;
                                err_q   <= 1'b1;
                            end
`endif
                        end
                    endcase
                end
                S_MEM: begin
                    if (!mem_is_ld_q) begin
                        out_data_q  <= ram_rdata_q[7:0];
                        out_valid_q <= 1'b1;
                    end
                    state_q <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Loader readback is only meaningful when the last read was the loader's.
    assign ld_rdata  = ld_valid_q ? ram_rdata_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign halted    = (state_q == S_HALT);
`ifdef N1_ILLEGAL_TRAP_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_n1_core.sv
// Self-checking bench for n1_core: directed program table, hand-written
// multi-cycle sequences and random programs checked against an ISA model.
module tb_n1_core;

    localparam int NREGS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ld_we = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_wdata = '0;
    logic [15:0] ld_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        busy;
    logic        halted;
`ifdef N1_ILLEGAL_TRAP_EN
    logic        err;
`endif

    n1_core dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_rdata  (ld_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .halted    (halted)
`ifdef N1_ILLEGAL_TRAP_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] shadow [256];
    int          exp_e[$];
    logic [7:0]  exp_v[$];
    int          exp_halt;
    bit          exp_err;
    int          got_e[$];
    logic [7:0]  got_v[$];
    int          got_halt;

    localparam logic [15:0] H = 16'h5000;

    function automatic logic [15:0] I(input int op, input int rd, input int imm);
        return {op[3:0], rd[2:0], 1'b0, imm[7:0]};
    endfunction

    function automatic logic [15:0] R(input int op, input int rd, input int rs);
        return {op[3:0], rd[2:0], rs[2:0], 6'b0};
    endfunction

    typedef logic [7:0][15:0] prog_t;

    function automatic prog_t mk(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    typedef struct {
        prog_t       prog;
        int          xa;
        logic [15:0] xd;
        int          n_out;
        logic [7:0]  out_v;
        int          out_e;
        int          halt_e;
        bit          err_e;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; ld_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        ld_addr = a[7:0]; ld_wdata = d; ld_we = 1'b1;
        @(posedge clk); #1;
        ld_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic read(input int a, output logic [15:0] d);
        ld_addr = a[7:0];
        @(posedge clk); #1;
        d = ld_rdata;
    endtask

    // Edge 0 is the edge that samples start; out/halt edges count from it.
    task automatic run(input int budget, input bit disturb, input bit with_load);
        got_e.delete(); got_v.delete(); got_halt = -1;
        start = 1'b1;
        if (with_load) ld_we = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ld_we = 1'b0;
        for (int e = 1; e <= budget; e++) begin
            if (disturb) begin
                ld_we = (e >= 3 && e < 7); ld_addr = 8'd70; ld_wdata = 16'hBEEF;
                start = (e == 5);
            end
            @(posedge clk); #1;
            if (out_valid) begin
                got_e.push_back(e); got_v.push_back(out_data);
            end
            if (halted) begin
                got_halt = e;
                break;
            end
        end
        ld_we = 1'b0; start = 1'b0;
        if (got_halt < 0) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: got no halt, expected halt within %0d cycles", budget);
        end
    endtask

    task automatic compare_run(input string tag);
        check($sformatf("%s_nout", tag), got_e.size(), exp_e.size());
        for (int i = 0; i < got_e.size() && i < exp_e.size(); i++) begin
            check($sformatf("%s_out%0d_edge", tag, i), got_e[i], exp_e[i]);
            check($sformatf("%s_out%0d_data", tag, i), got_v[i], exp_v[i]);
        end
        check($sformatf("%s_halt_edge", tag), got_halt, exp_halt);
        $display("run %s: %0d outputs, halted at edge %0d", tag, got_e.size(), got_halt);
    endtask

    // Instruction-level interpreter over the shadow RAM: 2 cycles per
    // instruction, 3 for LD/OUT, OUT visible the cycle after it completes.
    task automatic model_run();
        logic [15:0] r [8];
        logic [15:0] inst, rdv, rsv;
        int pc, s, op, rd, rs, a;
        for (int i = 0; i < 8; i++) r[i] = '0;
        pc = 0; s = 0;
        exp_e.delete(); exp_v.delete(); exp_halt = -1; exp_err = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            inst = shadow[pc];
            pc = (pc + 1) % 256;
            op = int'(inst[15:12]); rd = int'(inst[11:9]); rs = int'(inst[8:6]); a = int'(inst[7:0]);
            rdv = (rd < NREGS) ? r[rd] : 16'h0;
            rsv = (rs < NREGS) ? r[rs] : 16'h0;
            case (op)
                1: if (rd < NREGS) r[rd] = 16'(a);
                2: shadow[a] = rdv;
                3: if (rd < NREGS) r[rd] = shadow[a];
                4: begin exp_e.push_back(s + 3); exp_v.push_back(shadow[a][7:0]); end
                5: begin exp_halt = s + 2; return; end
                6: if (rd < NREGS) r[rd] = rdv + rsv;
                7: if (rd < NREGS) r[rd] = rdv - rsv;
                8: pc = a;
                9: if (rdv == 16'h0) pc = a;
                default: begin
`ifdef N1_ILLEGAL_TRAP_EN
                    if (op >= 10) begin exp_halt = s + 2; exp_err = 1'b1; return; end
`endif
                end
            endcase
            s += (op == 3 || op == 4) ? 3 : 2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        prog_t cd;
        cd = mk(I(1,0,3), I(1,1,1), R(7,0,1), I(9,0,5), I(8,0,2), I(2,0,41), I(4,0,41), H);
        tbl[0] = '{mk(I(1,1,5), I(2,1,40), I(4,0,40), H, H, H, H, H), -1, 16'h0, 1, 8'h05, 7, 9, 1'b0};
        tbl[1] = '{cd, -1, 16'h0, 1, 8'h00, 25, 27, 1'b0};
        tbl[2] = '{mk(I(3,2,50), I(1,3,1), R(6,2,3), I(2,2,51), I(4,0,51), H, H, H), 50, 16'hFFFF, 1, 8'h00, 12, 14, 1'b0};
        tbl[3] = '{mk(I(1,1,1), R(7,0,1), I(2,0,52), I(4,0,52), H, H, H, H), -1, 16'h0, 1, 8'hFF, 9, 11, 1'b0};
        tbl[4] = '{mk(I(1,1,8'h5A), I(2,1,60), I(3,2,60), I(2,2,61), I(4,0,61), H, H, H), -1, 16'h0, 1, 8'h5A, 12, 14, 1'b0};
        tbl[5] = '{mk(I(1,5,8'h77), I(2,5,62), I(4,0,62), H, H, H, H, H), -1, 16'h0, 1, 8'h00, 7, 9, 1'b0};
        tbl[6] = '{mk(I(9,1,255), I(2,1,64), I(4,0,64), H, H, H, H, H), 255, I(1,1,9), 1, 8'h09, 11, 13, 1'b0};
`ifdef N1_ILLEGAL_TRAP_EN
        tbl[7] = '{mk(16'hA000, I(1,1,8'h33), I(2,1,63), I(4,0,63), H, H, H, H), -1, 16'h0, 0, 8'h00, 0, 2, 1'b1};
`else
        tbl[7] = '{mk(16'hA000, I(1,1,8'h33), I(2,1,63), I(4,0,63), H, H, H, H), -1, 16'h0, 1, 8'h33, 9, 11, 1'b0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_ld_rdata", ld_rdata, 16'h0000);
`ifdef N1_ILLEGAL_TRAP_EN
        check("rst_err", err, 1'b0);
`endif
        rst = 1'b0;

        // Directed program table
        for (int k = 0; k < 8; k++) begin
            do_reset();
            for (int w = 0; w < 8; w++) load(w, tbl[k].prog[w]);
            if (tbl[k].xa >= 0) load(tbl[k].xa, tbl[k].xd);
            run(80, 1'b0, 1'b0);
            exp_e.delete(); exp_v.delete();
            if (tbl[k].n_out > 0) begin
                exp_e.push_back(tbl[k].out_e); exp_v.push_back(tbl[k].out_v);
            end
            exp_halt = tbl[k].halt_e;
            compare_run($sformatf("tbl%0d", k));
            if (tbl[k].n_out > 0) check($sformatf("tbl%0d_out_held", k), out_data, tbl[k].out_v);
            check($sformatf("tbl%0d_busy_at_halt", k), busy, 1'b0);
`ifdef N1_ILLEGAL_TRAP_EN
            check($sformatf("tbl%0d_err", k), err, tbl[k].err_e);
`endif
        end

        // Reset during the EXEC cycle of an ST: the store must not land
        for (int w = 0; w < 4; w++) load(w, tbl[0].prog[w]);
        load(40, 16'h1234);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_halted", halted, 1'b0);
        check("midrst_out_data", out_data, 8'h00);
        rst = 1'b0;
        for (int w = 0; w < 4; w++) begin
            read(w, d);
            check($sformatf("midrst_prog%0d", w), d, shadow[w]);
        end
        read(40, d);
        check("midrst_st_aborted", d, 16'h1234);
        $display("run midrst: reset during ST execute");

        // ld_we and start while busy are ignored; restart from HALT repeats
        do_reset();
        for (int w = 0; w < 8; w++) load(w, cd[w]);
        load(70, 16'h1111);
        exp_e.delete(); exp_v.delete();
        exp_e.push_back(25); exp_v.push_back(8'h00); exp_halt = 27;
        run(100, 1'b1, 1'b0);
        compare_run("busy_ignore");
        read(70, d);
        check("busy_ld_we_ignored", d, 16'h1111);
        run(100, 1'b0, 1'b0);
        compare_run("rerun");

        // start and ld_we together in IDLE: the write lands before fetch
        do_reset();
        for (int w = 1; w < 4; w++) load(w, tbl[0].prog[w]);
        ld_addr = 8'd0; ld_wdata = I(1,1,8'h66); shadow[0] = ld_wdata;
        exp_e.delete(); exp_v.delete();
        exp_e.push_back(7); exp_v.push_back(8'h66); exp_halt = 9;
        run(80, 1'b0, 1'b1);
        compare_run("start_with_load");

        // start with rst: reset wins
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 1'b0);
        @(posedge clk); #1;
        check("rst_start_busy_later", busy, 1'b0);
        check("rst_start_halted", halted, 1'b0);
        $display("run rst_start: start with reset");

        // Random forward-branching programs against the ISA model
        for (int p = 0; p < 20; p++) begin
            int len, op, rd, imm;
            do_reset();
            for (int a = 128; a < 144; a++) load(a, 16'($urandom));
            len = $urandom_range(6, 14);
            for (int i = 0; i < len - 1; i++) begin
                op  = $urandom_range(0, 15);
                rd  = $urandom_range(0, 7);
                imm = $urandom_range(0, 511);
                if (op == 5) op = 6;
                if (op == 8 || op == 9) imm = (imm & 256) | $urandom_range(i + 1, len - 1);
                if (op >= 2 && op <= 4) imm = (imm & 256) | (128 + $urandom_range(0, 15));
                load(i, {op[3:0], rd[2:0], imm[8:0]});
            end
            load(len - 1, H);
            model_run();
            run(400, 1'b0, 1'b0);
            compare_run($sformatf("rand%0d", p));
`ifdef N1_ILLEGAL_TRAP_EN
            check($sformatf("rand%0d_err", p), err, exp_err);
`endif
            for (int a = 128; a < 144; a++) begin
                read(a, d);
                check($sformatf("rand%0d_ram%0d", p, a), d, shadow[a]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/n1_core.md
Name: n1_core

Overview:
- Parametrised multi-cycle successor to the first-generation n1 CPU.
- Contains an internal program/data RAM, a register file and a FETCH/EXEC/MEM state machine.
- Adds arithmetic, loads, conditional branches, a loader port and an explicit halt/restart handshake.
- Sits inside the tt_um top, between the pin-level loader and output pins.

Parameters:
- DATA_W, 16: word width of RAM, registers and instructions (≥16).
- RAM_WORDS, 256: RAM depth, power of two, ≤256; ADDR_W = $clog2(RAM_WORDS).
- NUM_REGS, 4: general-purpose registers, 2..8.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution at pc 0; honoured only in IDLE or HALT.
- ld_we  in  1  loader write strobe; honoured only in IDLE or HALT.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_rdata  out  DATA_W  RAM[ld_addr], registered, 1-cycle latency, valid in IDLE/HALT.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- out_data  out  8  low byte of the last OUT value; held between pulses.
- busy  out  1  high in FETCH/EXEC/MEM.
- halted  out  1  high in HALT.

Behaviour:
- Reset values: state IDLE; pc=0; all registers 0; out_data=0; out_valid=0; ld_rdata=0; busy=0; halted=0.
- Reset does not clear RAM. A reset mid-run aborts the current instruction (no pending write completes) and returns to IDLE.
- States and transitions:
  - IDLE: start → FETCH with pc=0.
  - FETCH: RAM read at pc; pc ← pc+1, modulo RAM_WORDS (wraps at RAM_WORDS-1 → 0); → EXEC.
  - EXEC: inst = RAM read data; execute; → FETCH, or → MEM for LD/OUT, or → HALT.
  - MEM: complete LD/OUT; → FETCH.
  - HALT: start → FETCH with pc=0. Registers and RAM are retained.
- Instruction fields: op=inst[15:12], rd=inst[11:9], rs=inst[8:6], imm/addr=inst[7:0].
- Addresses are taken modulo RAM_WORDS. The immediate is zero-extended to DATA_W.
- Register index ≥ NUM_REGS: reads return 0; writes are dropped.
- Opcodes:
  - 0000 NOP.
  - 0001 MOVI rd←imm.
  - 0010 ST RAM[addr]←rd (write in EXEC).
  - 0011 LD: read issued in EXEC, rd←RAM[addr] in MEM.
  - 0100 OUT: read RAM[addr] in EXEC; in MEM out_data←low byte, out_valid=1.
  - 0101 HALT.
  - 0110 ADD rd←rd+rs.
  - 0111 SUB rd←rd−rs.
  - 1000 JMP pc←addr.
  - 1001 JZ: if rd==0 then pc←addr.
  - Others: NOP.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W; no flags are stored.
- Latency: 2 cycles per instruction; LD/OUT take 3.
- Same-address hazard: ST then LD of the same address returns the stored value, because the write lands in EXEC before the LD read.
- ld_we while busy is ignored; start while busy is ignored.
- start and ld_we in the same IDLE cycle: the write lands first, then the run begins.
- start asserted with rst: rst wins.

Optional Feature:
- Macro: N1_ILLEGAL_TRAP_EN.
- Defined:
  - Undefined opcodes (1010–1111) go to HALT.
  - Adds output port err (1 bit), set to 1 on that event.
  - err clears on rst or on an accepted start.
- Undefined: undefined opcodes execute as NOP; there is no err port.

Decomposition:
- Package n1_pkg holds:
  - opcode localparams;
  - the state enum (IDLE, FETCH, EXEC, MEM, HALT);
  - field-slice constants (OP_MSB, RD_LSB, RS_LSB, IMM_W=8).
- Sub-module n1_regfile: NUM_REGS×DATA_W, two combinational read ports, one write port, out-of-range handling included.
- RAM stays inline in n1_core: dual-access synchronous-read array, with the loader and core muxed by state.

Test Plan:
- Load {MOVI r1,5; ST r1,@40; OUT @40; HALT}; start → out_valid pulses once with out_data=0x05; halted=1 after 9 cycles from start.
- MOVI r0,3; MOVI r1,1; loop {SUB r0,r1; JZ r0,end; JMP loop}; end: HALT → halted with r0=0 after 2 iterations beyond the first; verify via ST/OUT → out_data=0x00.
- ADD wrap: r2=0xFFFF (via LD of preloaded word), r3=1, ADD r2,r3 → OUT shows 0x00; SUB 0−1 → low byte 0xFF.
- Assert rst two cycles into a run → IDLE, busy=0, out_data=0; previously loaded program readable unchanged on ld_rdata.
- ld_we while busy → RAM unchanged; start while busy ignored; start in HALT re-runs the program and produces an identical out_valid sequence.
- Opcode 0xA000: with N1_ILLEGAL_TRAP_EN → halted=1, err=1; without it → treated as NOP, next instruction executes.
